// File: rtl/fetch_queue.sv
// Fetch queue between the fetch and decode stages: a circular buffer of {pc, instr}
// entries with head-of-queue outputs and back-pressure to the PC register.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_pc,
    input  logic [WIDTH-1:0]         push_instr,
    output logic                     pc_en,
    input  logic                     pop_ready,
    output logic                     pop_valid,
    output logic [WIDTH-1:0]         pop_pc,
    output logic [WIDTH-1:0]         pop_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_pc_q    [DEPTH];
    logic [WIDTH-1:0] mem_instr_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push_acc;
    logic pop_acc;

    always_comb begin
        push_acc = push_valid && !flush && (count_q < FULL_COUNT);
        pop_acc  = (count_q != '0) && pop_ready && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap for free because DEPTH is a power of two.
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a write is suppressed while rst is asserted.
    always_ff @(posedge clk) begin
        if (rst && push_acc) begin
            mem_pc_q[wr_ptr_q]    <= push_pc;
            mem_instr_q[wr_ptr_q] <= push_instr;
        end
    end

    always_comb begin
        pc_en     = (count_q < FULL_COUNT);
        pop_valid = (count_q != '0);
        count     = count_q;
        pop_pc    = '0;
        pop_instr = '0;
        if (pop_valid) begin
            pop_pc    = mem_pc_q[rd_ptr_q];
            pop_instr = mem_instr_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table followed by random
// traffic compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] INSTR_TAG = 32'h1000_0000;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              push_valid;
    logic [WIDTH-1:0]  push_pc;
    logic [WIDTH-1:0]  push_instr;
    logic              pc_en;
    logic              pop_ready;
    logic              pop_valid;
    logic [WIDTH-1:0]  pop_pc;
    logic [WIDTH-1:0]  pop_instr;
    logic [$clog2(DEPTH):0] count;

    int tests_run;
    int tests_failed;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .pc_en      (pc_en),
        .pop_ready  (pop_ready),
        .pop_valid  (pop_valid),
        .pop_pc     (pop_pc),
        .pop_instr  (pop_instr),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        push;
        logic [31:0] pc;
        logic        pop;
        int          exp_count;
        logic [31:0] exp_pc;     // head PC after the edge; empty queue when exp_count == 0
        string       name;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t model_q[$];

    task automatic add(input logic r, input logic f, input logic pu, input logic [31:0] pc,
                       input logic po, input int ec, input logic [31:0] epc, input string nm);
        vec_t v;
        v.rst_n = r; v.flush = f; v.push = pu; v.pc = pc; v.pop = po;
        v.exp_count = ec; v.exp_pc = epc; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic pu, input logic [31:0] pc,
                        input logic [31:0] ins, input logic po);
        rst = r; flush = f; push_valid = pu; push_pc = pc; push_instr = ins; pop_ready = po;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string nm, input int ec, input logic [31:0] epc,
                                 input logic [31:0] eins);
        logic ev;
        ev = (ec != 0);
        check({nm, ".count"},     64'(count),     64'(ec));
        check({nm, ".pop_valid"}, 64'(pop_valid), 64'(ev));
        check({nm, ".pop_pc"},    64'(pop_pc),    ev ? 64'(epc) : 64'd0);
        check({nm, ".pop_instr"}, 64'(pop_instr), ev ? 64'(eins) : 64'd0);
        check({nm, ".pc_en"},     64'(pc_en),     64'(ec < DEPTH));
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b0; flush = 1'b0; push_valid = 1'b0; push_pc = '0; push_instr = '0; pop_ready = 1'b0;

        // Reset and fill to full; fifth push refused
        add(0, 0, 0, 32'h0,  0, 0, 32'h0, "reset");
        add(1, 0, 1, 32'h0,  0, 1, 32'h0, "fill1");
        add(1, 0, 1, 32'h4,  0, 2, 32'h0, "fill2");
        add(1, 0, 1, 32'h8,  0, 3, 32'h0, "fill3");
        add(1, 0, 1, 32'hC,  0, 4, 32'h0, "fill4");
        add(1, 0, 1, 32'h10, 0, 4, 32'h0, "push_full");
        // Drain in order, then pop on empty
        add(1, 0, 0, 32'h0,  1, 3, 32'h4, "drain1");
        add(1, 0, 0, 32'h0,  1, 2, 32'h8, "drain2");
        add(1, 0, 0, 32'h0,  1, 1, 32'hC, "drain3");
        add(1, 0, 0, 32'h0,  1, 0, 32'h0, "drain4");
        add(1, 0, 0, 32'h0,  1, 0, 32'h0, "pop_empty");
        // Full with simultaneous push and pop
        add(1, 0, 1, 32'h20, 0, 1, 32'h20, "refill1");
        add(1, 0, 1, 32'h24, 0, 2, 32'h20, "refill2");
        add(1, 0, 1, 32'h28, 0, 3, 32'h20, "refill3");
        add(1, 0, 1, 32'h2C, 0, 4, 32'h20, "refill4");
        add(1, 0, 1, 32'h30, 1, 3, 32'h24, "full_pushpop");
        // Flush with push and pop requested
        add(1, 1, 1, 32'h40, 1, 0, 32'h0, "flush");
        add(1, 0, 0, 32'h0,  0, 0, 32'h0, "post_flush");
        // Steady push+pop at occupancy 2 across pointer wrap
        add(1, 0, 1, 32'h100, 0, 1, 32'h100, "wrap_pre1");
        add(1, 0, 1, 32'h104, 0, 2, 32'h100, "wrap_pre2");
        for (int k = 0; k < 10; k++)
            add(1, 0, 1, 32'h108 + 32'(4 * k), 1, 2, 32'h104 + 32'(4 * k), $sformatf("wrap%0d", k));
        add(1, 0, 0, 32'h0, 1, 1, 32'h12C, "wrap_drain1");
        add(1, 0, 0, 32'h0, 1, 0, 32'h0,   "wrap_drain2");
        // Reset mid-run, together with flush, push and pop
        add(1, 0, 1, 32'h200, 0, 1, 32'h200, "mid1");
        add(1, 0, 1, 32'h204, 0, 2, 32'h200, "mid2");
        add(0, 1, 1, 32'h208, 1, 0, 32'h0,   "mid_reset");
        add(1, 0, 0, 32'h0,   0, 0, 32'h0,   "post_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].flush, vecs[i].push, vecs[i].pc,
                 vecs[i].pc + INSTR_TAG, vecs[i].pop);
            check_outputs(vecs[i].name, vecs[i].exp_count, vecs[i].exp_pc, vecs[i].exp_pc + INSTR_TAG);
        end

        // Hand sequence: the refused push while full must never surface later
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) step(1, 0, 1, 32'h300 + 32'(4 * k), 32'h9000 + 32'(k), 0);
        step(1, 0, 1, 32'hDEAD, 32'hBEEF, 1);
        for (int k = 1; k < DEPTH; k++) begin
            check_outputs($sformatf("no_ghost%0d", k), DEPTH - k, 32'h300 + 32'(4 * k), 32'h9000 + 32'(k));
            step(1, 0, 0, 0, 0, 1);
        end
        check_outputs("no_ghost_end", 0, 0, 0);

        // Random traffic against the reference model
        step(0, 0, 0, 0, 0, 0);
        model_q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic r, f, pu, po;
            logic [31:0] pc, ins;
            entry_t e;
            r   = ($urandom_range(0, 63) != 0);
            f   = ($urandom_range(0, 15) == 0);
            pu  = ($urandom_range(0, 3) != 0);
            po  = ($urandom_range(0, 2) != 0);
            pc  = $urandom;
            ins = $urandom;
            if (!r || f) begin
                model_q.delete();
            end else begin
                logic can_pop, can_push;
                can_pop  = po && (model_q.size() != 0);
                can_push = pu && (model_q.size() < DEPTH);
                if (can_pop) void'(model_q.pop_front());
                if (can_push) begin
                    e.pc = pc; e.instr = ins;
                    model_q.push_back(e);
                end
            end
            step(r, f, pu, pc, ins, po);
            if (model_q.size() != 0)
                check_outputs($sformatf("rand%0d", n), model_q.size(), model_q[0].pc, model_q[0].instr);
            else
                check_outputs($sformatf("rand%0d", n), 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
